cgra_config_sequencer: RTL

Controller sitting in front of the elastic CGRA array. Accepts a stream of per-PE configuration records over a valid/ready handshake. Range-checks each record and replays it onto the array's shared config-load bus as single-cycle writes. It then drives the execution-start level for a programmed number of cycles and reports completion and error status to the host.

---
 rtl/cgra_config_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cgra_config_sequencer.sv
// Config sequencer for the CGRA array: accepts per-PE config records,
// range-checks them, replays valid ones as single-cycle config writes,
// then drives the execution-start level for a programmed number of cycles.
module cgra_config_sequencer #(
  parameter int unsigned PE_ROW_SIZE             = 4,
  parameter int unsigned PE_COLUMN_SIZE          = 4,
  parameter int unsigned PE_ROW_BIT_LENGTH       = 2,
  parameter int unsigned PE_COLUMN_BIT_LENGTH    = 2,
  parameter int unsigned INPUT_NUM_BIT_LENGTH    = 3,
  parameter int unsigned NEIGHBOR_PE_NUM         = 4,
  parameter int unsigned OPERATION_BIT_LENGTH    = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned CONTEXT_SIZE_BIT_LENGTH = 3,
  parameter int unsigned RUN_CYCLE_WIDTH         = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_start,
  input  logic                               cmd_abort,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] context_max_id,
  input  logic [RUN_CYCLE_WIDTH-1:0]         run_cycles,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [PE_ROW_BIT_LENGTH-1:0]       cfg_row,
  input  logic [PE_COLUMN_BIT_LENGTH-1:0]    cfg_col,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_1,
  input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_2,
  input  logic [NEIGHBOR_PE_NUM-1:0]         cfg_output,
  input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
  input  logic [DATA_WIDTH-1:0]              cfg_const,
  input  logic                               cfg_last,
  output logic [PE_ROW_BIT_LENGTH-1:0]       config_PE_row_index,
  output logic [PE_COLUMN_BIT_LENGTH-1:0]    config_PE_column_index,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
  output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
  output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
  output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
  output logic [DATA_WIDTH-1:0]              config_const_data,
  output logic                               write_config_data,
  output logic                               start_exec,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [7:0]                         reject_count,
  output logic [15:0]                        load_count,
  output logic [RUN_CYCLE_WIDTH-1:0]         exec_cycle_count
);

  localparam int unsigned REJ_W  = 8;
  localparam int unsigned LOAD_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [PE_ROW_BIT_LENGTH-1:0]       row;
    logic [PE_COLUMN_BIT_LENGTH-1:0]    col;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    in2;
    logic [NEIGHBOR_PE_NUM-1:0]         outm;
    logic [OPERATION_BIT_LENGTH-1:0]    op;
    logic [DATA_WIDTH-1:0]              cst;
  } cfg_bus_t;

  state_e                             state_q, state_d;
  cfg_bus_t                           rec_in, bus_q, bus_d;
  logic                               wr_q, wr_d;
  logic                               start_exec_q, start_exec_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic                               error_q, error_d;
  logic [REJ_W-1:0]                   rej_cnt_q, rej_cnt_d;
  logic [LOAD_W-1:0]                  load_cnt_q, load_cnt_d;
  logic [RUN_CYCLE_WIDTH-1:0]         exec_cnt_q, exec_cnt_d;
  logic [RUN_CYCLE_WIDTH-1:0]         run_len_q, run_len_d;
  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] max_id_q, max_id_d;

  logic row_bad, col_bad, ctx_bad, rec_bad;
  logic cfg_fire, wr_fire, rej_fire, session_start, run_last;

  assign rec_in = {cfg_row, cfg_col, cfg_context, cfg_input_1, cfg_input_2,
                   cfg_output, cfg_op, cfg_const};

  // Row/column range checks only exist when the index field can exceed the array
  if (PE_ROW_SIZE < (1 << PE_ROW_BIT_LENGTH)) begin : g_row_chk
    assign row_bad = (cfg_row >= PE_ROW_BIT_LENGTH'(PE_ROW_SIZE));
  end else begin : g_row_full
    assign row_bad = 1'b0;
  end

  if (PE_COLUMN_SIZE < (1 << PE_COLUMN_BIT_LENGTH)) begin : g_col_chk
    assign col_bad = (cfg_col >= PE_COLUMN_BIT_LENGTH'(PE_COLUMN_SIZE));
  end else begin : g_col_full
    assign col_bad = 1'b0;
  end

  assign ctx_bad = (cfg_context > max_id_q);
  assign rec_bad = row_bad | col_bad | ctx_bad;

  // Abort wins over a concurrent record, so the handshake is withheld too
  assign cfg_ready     = (state_q == S_LOAD) & ~cmd_abort;
  assign cfg_fire      = cfg_valid & cfg_ready;
  assign wr_fire       = cfg_fire & ~rec_bad;
  assign rej_fire      = cfg_fire & rec_bad;
  assign session_start = cmd_start & ~cmd_abort &
                         ((state_q == S_IDLE) | (state_q == S_DONE));
  assign run_last      = (state_q == S_RUN) && (run_len_q != '0) &&
                         (exec_cnt_q == run_len_q - RUN_CYCLE_WIDTH'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (cmd_start) state_d = S_LOAD;
      S_LOAD:         if (cfg_fire && cfg_last) state_d = S_FLUSH;
      S_FLUSH:        state_d = S_RUN;
      S_RUN:          if (run_last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (cmd_abort) state_d = S_IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next values for the config bus, status flags and counters
  always_comb begin
    bus_d        = wr_fire ? rec_in : bus_q;
    wr_d         = wr_fire;
    start_exec_d = (state_d == S_RUN);
    busy_d       = (state_d == S_LOAD) | (state_d == S_FLUSH) | (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
    error_d      = error_q;
    rej_cnt_d    = rej_cnt_q;
    load_cnt_d   = load_cnt_q;
    exec_cnt_d   = exec_cnt_q;
    run_len_d    = run_len_q;
    max_id_d     = max_id_q;
    if (session_start) begin
      error_d    = 1'b0;
      rej_cnt_d  = '0;
      load_cnt_d = '0;
      exec_cnt_d = '0;
      run_len_d  = run_cycles;
      max_id_d   = context_max_id;
    end else begin
      if (rej_fire) begin
        error_d = 1'b1;
        if (rej_cnt_q != '1) rej_cnt_d = rej_cnt_q + REJ_W'(1);
      end
      if (wr_fire && (load_cnt_q != '1)) load_cnt_d = load_cnt_q + LOAD_W'(1);
      if ((state_q == S_RUN) && !cmd_abort && !run_last)
        exec_cnt_d = exec_cnt_q + RUN_CYCLE_WIDTH'(1);
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q        <= '0;
      wr_q         <= 1'b0;
      start_exec_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      rej_cnt_q    <= '0;
      load_cnt_q   <= '0;
      exec_cnt_q   <= '0;
      run_len_q    <= '0;
      max_id_q     <= '0;
    end else begin
      bus_q        <= bus_d;
      wr_q         <= wr_d;
      start_exec_q <= start_exec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      rej_cnt_q    <= rej_cnt_d;
      load_cnt_q   <= load_cnt_d;
      exec_cnt_q   <= exec_cnt_d;
      run_len_q    <= run_len_d;
      max_id_q     <= max_id_d;
    end
  end

  assign config_PE_row_index     = bus_q.row;
  assign config_PE_column_index  = bus_q.col;
  assign config_index            = bus_q.ctx;
  assign config_input_PE_index_1 = bus_q.in1;
  assign config_input_PE_index_2 = bus_q.in2;
  assign config_output_PE_index  = bus_q.outm;
  assign config_op               = bus_q.op;
  assign config_const_data       = bus_q.cst;
  assign write_config_data       = wr_q;
  assign start_exec              = start_exec_q;
  assign mapping_context_max_id  = max_id_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign error                   = error_q;
  assign reject_count            = rej_cnt_q;
  assign load_count              = load_cnt_q;
  assign exec_cycle_count        = exec_cnt_q;

endmodule
